// File: rtl/ctrl_pipe.sv
// ctrl_pipe: RV32 decode stage with a registered control bundle.
// Ports: clk/reset; insn_i, pc_i, insn_valid_i, insn_ready_o (fetch side);
//   ex_ready_i, flush_i (execute side); ctrl_valid_o, control bits,
//   wbsel_o, alusel_o, rd_o/rs1_o/rs2_o, pc_o (output register);
//   illegal_o (halted on an illegal opcode).
module ctrl_pipe #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned TRAP_ILLEGAL = 1,
  parameter int unsigned HAZARD_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic              insn_valid_i,
  output logic              insn_ready_o,
  input  logic              ex_ready_i,
  input  logic              flush_i,
  output logic              ctrl_valid_o,
  output logic              pcsel_o,
  output logic              immsel_o,
  output logic              regwren_o,
  output logic              rs1sel_o,
  output logic              rs2sel_o,
  output logic              memren_o,
  output logic              memwren_o,
  output logic [1:0]        wbsel_o,
  output logic [3:0]        alusel_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [DWIDTH-1:0] pc_o,
  output logic              illegal_o
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_BUBBLE = 2'd1;
  localparam logic [1:0] S_HALT   = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_JAL = 2'd2;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;

  typedef struct packed {
    logic       pcsel;
    logic       immsel;
    logic       regwren;
    logic       rs1sel;
    logic       rs2sel;
    logic       memren;
    logic       memwren;
    logic [1:0] wbsel;
    logic [3:0] alusel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic [3:0] w_alu;
  ctrl_t      w_dec;
  logic       w_illegal;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_hazard;
  logic       w_hold;
  logic       w_accept;
  logic       w_trap;
  logic       w_take;

  logic [1:0]        r_state;
  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [DWIDTH-1:0] r_pc;

  assign w_op  = insn_i[6:0];
  assign w_rd  = insn_i[11:7];
  assign w_f3  = insn_i[14:12];
  assign w_rs1 = insn_i[19:15];
  assign w_rs2 = insn_i[24:20];
  assign w_f7  = insn_i[31:25];

  // bit 30 picks SUB/SRA; ADDI overrides this since its bit 30 is imm
  always_comb begin
    w_alu = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu = w_f7[5] ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu = ALU_SLL;
      3'b010:  w_alu = ALU_SLT;
      3'b011:  w_alu = ALU_SLTU;
      3'b100:  w_alu = ALU_XOR;
      3'b101:  w_alu = w_f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu = ALU_OR;
      default: w_alu = ALU_AND;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.rd      = w_rd;
    w_dec.rs1     = w_rs1;
    w_dec.rs2     = w_rs2;
    w_illegal     = 1'b0;
    w_use_rs1     = 1'b0;
    w_use_rs2     = 1'b0;
    case (w_op)
      OP_R: begin
        w_dec.regwren = 1'b1;
        w_dec.alusel  = w_alu;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
        if (w_f7 != 7'h00 &&
            !(w_f7 == 7'h20 &&
              (w_f3 == 3'b000 || w_f3 == 3'b101)))
          w_illegal = 1'b1;
      end
      OP_I: begin
        w_dec.regwren = 1'b1;
        w_dec.rs2sel  = 1'b1;
        w_dec.alusel  = (w_f3 == 3'b000) ? ALU_ADD : w_alu;
        w_use_rs1     = 1'b1;
        if (w_f3 == 3'b001 && w_f7 != 7'h00)
          w_illegal = 1'b1;
        if (w_f3 == 3'b101 && w_f7 != 7'h00 &&
            w_f7 != 7'h20)
          w_illegal = 1'b1;
      end
      OP_LOAD: begin
        w_dec.memren  = 1'b1;
        w_dec.wbsel   = WB_MEM;
        w_dec.regwren = 1'b1;
        w_dec.rs2sel  = 1'b1;
        w_use_rs1     = 1'b1;
      end
      OP_STORE: begin
        w_dec.memwren = 1'b1;
        w_dec.immsel  = 1'b1;
        w_use_rs1     = 1'b1;
        w_use_rs2     = 1'b1;
      end
      OP_LUI: begin
        w_dec.regwren = 1'b1;
        w_dec.rs1sel  = 1'b1;
        w_dec.rs2sel  = 1'b1;
        w_dec.rs1     = 5'd0;
      end
      OP_AUIPC: begin
        w_dec.regwren = 1'b1;
        w_dec.rs1sel  = 1'b1;
        w_dec.rs2sel  = 1'b1;
      end
      OP_BR: begin
        w_dec.pcsel  = 1'b1;
        w_dec.rs1sel = 1'b1;
        w_dec.rs2sel = 1'b1;
        w_use_rs1    = 1'b1;
        w_use_rs2    = 1'b1;
      end
      OP_JAL: begin
        w_dec.pcsel   = 1'b1;
        w_dec.regwren = 1'b1;
        w_dec.wbsel   = WB_JAL;
        w_dec.rs1sel  = 1'b1;
        w_dec.rs2sel  = 1'b1;
      end
      OP_JALR: begin
        w_dec.pcsel   = 1'b1;
        w_dec.regwren = 1'b1;
        w_dec.wbsel   = WB_JAL;
        w_dec.rs2sel  = 1'b1;
        w_use_rs1     = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_dec     = '0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
    end
  end

  // load in the output register feeding the incoming instruction
  assign w_hazard = (HAZARD_EN != 0) && r_valid &&
                    r_ctrl.memren && (r_ctrl.rd != 5'd0) &&
                    insn_valid_i &&
                    ((w_use_rs1 && w_rs1 == r_ctrl.rd) ||
                     (w_use_rs2 && w_rs2 == r_ctrl.rd));

  assign w_hold   = r_valid && !ex_ready_i;
  assign insn_ready_o = (r_state != S_HALT) &&
                        (ex_ready_i || !r_valid) && !w_hazard;
  assign w_accept = insn_valid_i && insn_ready_o && !flush_i;
  assign w_trap   = w_accept && w_illegal && (TRAP_ILLEGAL != 0);
  assign w_take   = w_accept && !w_trap;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      r_state <= S_RUN;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_pc    <= '0;
    end else if (!w_hold) begin
      unique case (1'b1)
        w_hazard: begin
          r_state <= S_BUBBLE;
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_pc    <= '0;
        end
        w_trap: begin
          r_state <= S_HALT;
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_pc    <= '0;
        end
        w_take: begin
          r_state <= S_RUN;
          r_valid <= 1'b1;
          r_ctrl  <= w_dec;
          r_pc    <= pc_i;
        end
        default: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_pc    <= '0;
          if (r_state != S_HALT)
            r_state <= S_RUN;
        end
      endcase
    end
  end

  assign ctrl_valid_o = r_valid;
  assign pcsel_o      = r_ctrl.pcsel;
  assign immsel_o     = r_ctrl.immsel;
  assign regwren_o    = r_ctrl.regwren;
  assign rs1sel_o     = r_ctrl.rs1sel;
  assign rs2sel_o     = r_ctrl.rs2sel;
  assign memren_o     = r_ctrl.memren;
  assign memwren_o    = r_ctrl.memwren;
  assign wbsel_o      = r_ctrl.wbsel;
  assign alusel_o     = r_ctrl.alusel;
  assign rd_o         = r_ctrl.rd;
  assign rs1_o        = r_ctrl.rs1;
  assign rs2_o        = r_ctrl.rs2;
  assign pc_o         = r_pc;
  assign illegal_o    = (r_state == S_HALT);

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed scenarios plus random traffic for ctrl_pipe,
// checked against an instruction-class reference model.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn_i = '0;
  logic [31:0] pc_i = '0;
  logic        insn_valid_i = 1'b0;
  logic        insn_ready_o;
  logic        ex_ready_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        ctrl_valid_o;
  logic        pcsel_o, immsel_o, regwren_o, rs1sel_o;
  logic        rs2sel_o, memren_o, memwren_o;
  logic [1:0]  wbsel_o;
  logic [3:0]  alusel_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [31:0] pc_o;
  logic        illegal_o;

  ctrl_pipe #(
    .DWIDTH(32), .TRAP_ILLEGAL(1), .HAZARD_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .insn_i(insn_i),
    .pc_i(pc_i), .insn_valid_i(insn_valid_i),
    .insn_ready_o(insn_ready_o),
    .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .ctrl_valid_o(ctrl_valid_o), .pcsel_o(pcsel_o),
    .immsel_o(immsel_o), .regwren_o(regwren_o),
    .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
    .memren_o(memren_o), .memwren_o(memwren_o),
    .wbsel_o(wbsel_o), .alusel_o(alusel_o),
    .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .pc_o(pc_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        pcsel;
    logic        immsel;
    logic        regwren;
    logic        rs1sel;
    logic        rs2sel;
    logic        memren;
    logic        memwren;
    logic [1:0]  wbsel;
    logic [3:0]  alusel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
  } exp_t;

  typedef enum int {
    C_R, C_I, C_LD, C_ST, C_LUI, C_AUIPC,
    C_BR, C_JAL, C_JALR, C_BAD
  } cls_e;

  localparam logic [31:0] SUB3 = 32'h402081B3;
  localparam logic [31:0] LW5  = 32'h0000A283;
  localparam logic [31:0] ADD6 = 32'h00028333;
  localparam logic [31:0] LW0  = 32'h0000A003;
  localparam logic [31:0] ADD0 = 32'h00000333;
  localparam logic [31:0] BAD7F = 32'h0000007F;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t m = '0;
  bit   m_halt = 1'b0;
  int   lut [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  function automatic cls_e classify(input logic [31:0] x);
    logic [6:0] f7 = x[31:25];
    logic [2:0] f3 = x[14:12];
    case (x[6:0])
      7'h33: begin
        if (f7 == 7'h00) return C_R;
        if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
          return C_R;
        return C_BAD;
      end
      7'h13: begin
        if (f3 == 3'd1 && f7 != 7'h00) return C_BAD;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
          return C_BAD;
        return C_I;
      end
      7'h03: return C_LD;
      7'h23: return C_ST;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      7'h63: return C_BR;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      default: return C_BAD;
    endcase
  endfunction

  function automatic exp_t model_decode(
    input logic [31:0] x, input logic [31:0] pc);
    cls_e       c = classify(x);
    logic [2:0] f3 = x[14:12];
    logic [6:0] t;
    exp_t       e = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    if (c == C_BAD) return e;
    // pcsel immsel regwren rs1sel rs2sel memren memwren
    case (c)
      C_R:     t = 7'b0010000;
      C_I:     t = 7'b0010100;
      C_LD:    t = 7'b0010110;
      C_ST:    t = 7'b0100001;
      C_LUI:   t = 7'b0011100;
      C_AUIPC: t = 7'b0011100;
      C_BR:    t = 7'b1001100;
      C_JAL:   t = 7'b1011100;
      C_JALR:  t = 7'b1010100;
      default: t = 7'b0000000;
    endcase
    {e.pcsel, e.immsel, e.regwren, e.rs1sel,
     e.rs2sel, e.memren, e.memwren} = t;
    if (c == C_LD) e.wbsel = 2'd1;
    if (c == C_JAL || c == C_JALR) e.wbsel = 2'd2;
    if (c == C_R)
      e.alusel = 4'(lut[f3] +
        ((x[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 1 : 0));
    if (c == C_I)
      e.alusel = 4'(lut[f3] + ((x[30] && f3 == 3'd5) ? 1 : 0));
    e.rd  = x[11:7];
    e.rs1 = (c == C_LUI) ? 5'd0 : x[19:15];
    e.rs2 = x[24:20];
    return e;
  endfunction

  function automatic bit reads(
    input logic [31:0] x, input logic [4:0] r);
    cls_e c = classify(x);
    bit u1 = c inside {C_R, C_I, C_LD, C_ST, C_BR, C_JALR};
    bit u2 = c inside {C_R, C_ST, C_BR};
    return (u1 && x[19:15] == r) || (u2 && x[24:20] == r);
  endfunction

  function automatic bit m_ready();
    if (m_halt) return 1'b0;
    if (m.valid && !ex_ready_i) return 1'b0;
    if (insn_valid_i && m.valid && m.memren &&
        m.rd != 5'd0 && reads(insn_i, m.rd))
      return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t obs();
    exp_t o;
    o = {ctrl_valid_o, pcsel_o, immsel_o, regwren_o,
         rs1sel_o, rs2sel_o, memren_o, memwren_o,
         wbsel_o, alusel_o, rd_o, rs1_o, rs2_o, pc_o};
    return o;
  endfunction

  function automatic logic [31:0] rand_insn(input bit allow_bad);
    logic [31:0] x = $urandom;
    logic [2:0]  f3 = x[14:12];
    bit          b = x[31];
    x[11:7]  = 5'($urandom_range(0, 3));
    x[19:15] = 5'($urandom_range(0, 3));
    x[24:20] = 5'($urandom_range(0, 3));
    if (allow_bad && $urandom_range(0, 24) == 0) begin
      case ($urandom_range(0, 2))
        0: x[6:0] = 7'h7F;
        1: begin x[6:0] = 7'h33; x[31:25] = 7'h01; end
        default: x[6:0] = 7'h73;
      endcase
      return x;
    end
    case ($urandom_range(0, 8))
      0: begin
        x[6:0] = 7'h33;
        x[31:25] = ((f3 == 3'd0 || f3 == 3'd5) && b)
                   ? 7'h20 : 7'h00;
      end
      1: begin
        x[6:0] = 7'h13;
        if (f3 == 3'd1) x[31:25] = 7'h00;
        if (f3 == 3'd5) x[31:25] = b ? 7'h20 : 7'h00;
      end
      2: x[6:0] = 7'h03;
      3: x[6:0] = 7'h23;
      4: x[6:0] = 7'h37;
      5: x[6:0] = 7'h17;
      6: x[6:0] = 7'h63;
      7: x[6:0] = 7'h6F;
      default: x[6:0] = 7'h67;
    endcase
    return x;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins,
    input logic [31:0] pc, input logic exr,
    input logic fl, input logic rst);
    @(negedge clk);
    insn_valid_i = v;
    insn_i       = ins;
    pc_i         = pc;
    ex_ready_i   = exr;
    flush_i      = fl;
    reset        = rst;
    #1;
  endtask

  // advance the reference model by one clock using current inputs
  task automatic tick();
    exp_t n = '0;
    bit   h = m_halt;
    bit   rdy = m_ready();
    if (reset || flush_i) begin
      h = 1'b0;
    end else if (m.valid && !ex_ready_i) begin
      n = m;
    end else if (insn_valid_i && rdy) begin
      if (classify(insn_i) == C_BAD) h = 1'b1;
      else n = model_decode(insn_i, pc_i);
    end
    @(posedge clk);
    #1;
    m      = n;
    m_halt = h;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs() !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs());
    end
    vectors++;
    if (illegal_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_illegal: got %b want 0", illegal_o);
    end
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", insn_ready_o);
    end
    tick();
  endtask

  task automatic test_sub();
    drive(1'b1, SUB3, 32'h100, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_ready: got %b want 1", insn_ready_o);
    end
    tick();
    vectors++;
    if (alusel_o !== 4'd1 || regwren_o !== 1'b1 ||
        rd_o !== 5'd3 || ctrl_valid_o !== 1'b1 ||
        pc_o !== 32'h100) begin
      miscompares++;
      $display("FAIL sub_fields: got alu=%h wr=%b rd=%0d v=%b pc=%h want alu=1 wr=1 rd=3 v=1 pc=100",
        alusel_o, regwren_o, rd_o, ctrl_valid_o, pc_o);
    end
    vectors++;
    if (obs() !== m) begin
      miscompares++;
      $display("FAIL sub_bundle: got %h want %h", obs(), m);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b1, LW5, 32'h200, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD6, 32'h204, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_stall_ready: got %b want 0", insn_ready_o);
    end
    tick();
    vectors++;
    if (ctrl_valid_o !== 1'b0 || obs() !== '0) begin
      miscompares++;
      $display("FAIL lu_bubble: got %h want 0", obs());
    end
    drive(1'b1, ADD6, 32'h204, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_resume_ready: got %b want 1", insn_ready_o);
    end
    tick();
    vectors++;
    if (ctrl_valid_o !== 1'b1 || rd_o !== 5'd6 ||
        pc_o !== 32'h204 || obs() !== m) begin
      miscompares++;
      $display("FAIL lu_add_out: got %h want %h", obs(), m);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_no_hazard_x0();
    drive(1'b1, LW0, 32'h240, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD0, 32'h244, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_ready: got %b want 1", insn_ready_o);
    end
    tick();
    vectors++;
    if (ctrl_valid_o !== 1'b1 || rd_o !== 5'd6 ||
        pc_o !== 32'h244) begin
      miscompares++;
      $display("FAIL x0_add_out: got %h want %h", obs(), m);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, BAD7F, 32'h300, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, rand_insn(1'b0), 32'h304, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (illegal_o !== 1'b1 || insn_ready_o !== 1'b0 ||
          ctrl_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold[%0d]: got ill=%b rdy=%b v=%b want 1 0 0",
          i, illegal_o, insn_ready_o, ctrl_valid_o);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    tick();
    vectors++;
    if (illegal_o !== 1'b0 || ctrl_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_flush: got ill=%b v=%b want 0 0",
        illegal_o, ctrl_valid_o);
    end
    drive(1'b1, SUB3, 32'h310, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_resume_ready: got %b want 1", insn_ready_o);
    end
    tick();
    vectors++;
    if (obs() !== m || ctrl_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_resume_out: got %h want %h", obs(), m);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_stall();
    exp_t snap;
    drive(1'b1, ADD6, 32'h400, 1'b1, 1'b0, 1'b0);
    tick();
    snap = obs();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, SUB3, 32'h404, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (insn_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b want 0",
          i, insn_ready_o);
      end
      tick();
      vectors++;
      if (obs() !== snap || ctrl_valid_o !== 1'b1 ||
          pc_o !== 32'h400) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h want %h",
          i, obs(), snap);
      end
    end
    drive(1'b1, SUB3, 32'h404, 1'b1, 1'b1, 1'b0);
    tick();
    vectors++;
    if (ctrl_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_capture: got v=%b want 0", ctrl_valid_o);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, LW5, 32'h500, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD6, 32'h504, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, ADD6, 32'h504, 1'b1, 1'b0, 1'b1);
    tick();
    vectors++;
    if (obs() !== '0 || illegal_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bubble: got %h ill=%b want 0 0",
        obs(), illegal_o);
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_bubble_ready: got %b want 1", insn_ready_o);
    end
    tick();
    drive(1'b1, BAD7F, 32'h510, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (illegal_o !== 1'b0 || insn_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_halt: got ill=%b rdy=%b want 0 1",
        illegal_o, insn_ready_o);
    end
    tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, rand_insn(1'b1),
        $urandom, $urandom_range(0, 3) != 0,
        $urandom_range(0, 19) == 0, 1'b0);
      exp_rdy = m_ready();
      vectors++;
      if (insn_ready_o !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d]: got %b want %b",
          i, insn_ready_o, exp_rdy);
      end
      tick();
      vectors++;
      if (obs() !== m || illegal_o !== m_halt) begin
        miscompares++;
        $display("FAIL rnd_out[%0d]: got %h ill=%b want %h ill=%b",
          i, obs(), illegal_o, m, m_halt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_load_use();
    test_no_hazard_x0();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
